ff_seq_ctrl: RTL and testbench

FF_SEQ_CTRL -- requirements
Module: ff_seq_ctrl

---
 rtl/ff_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_ff_seq_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ff_seq_ctrl.sv
// ff_seq_ctrl: sequenced 3-bit counter controller with up, down and optional
// Gray coding, hold/stop control and a programmable number of wraps per run.
// Optional feature: define FF_SEQ_GRAY_EN to let MODE=2'b10 select Gray output;
// without it MODE=2'b10 counts up and no Gray encoder is built.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for START, count forced to 0
// ST_RUN   | counter advances once per clock
// ST_HOLD  | counter frozen while HOLD is high
// ST_FIN   | one-cycle completion state after the final wrap
module ff_seq_ctrl (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       STOP,
    input  logic       HOLD,
    input  logic [1:0] MODE,
    input  logic [2:0] LIMIT,
    input  logic [3:0] CYCLES,
    output logic       Q2,
    output logic       Q1,
    output logic       Q0,
    output logic       BUSY,
    output logic       WRAP,
    output logic       DONE
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_GRAY = 2'b10;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;        // binary count (Gray is derived from it)
    logic [3:0]  wcnt_q, wcnt_d;      // wraps completed in this run
    logic [1:0]  mode_q, mode_d;
    logic [2:0]  limit_q, limit_d;
    logic [3:0]  cycles_q, cycles_d;
    logic [2:0]  q_q, q_d;
    logic        busy_q, busy_d;
    logic        wrap_q, wrap_d;
    logic        done_q, done_d;

    logic        down_run;
    logic        at_term;
    logic [2:0]  start_val;
    logic [3:0]  wcnt_inc;

    assign down_run  = (mode_q == MODE_DOWN);
    assign start_val = down_run ? limit_q : 3'd0;
    assign at_term   = down_run ? (cnt_q == 3'd0) : (cnt_q == limit_q);
    assign wcnt_inc  = wcnt_q + 4'd1;

    // Next-state, counter and registered-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        mode_d   = mode_q;
        limit_d  = limit_q;
        cycles_d = cycles_q;
        wrap_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 3'd0;
                if (START && !STOP) begin
                    state_d  = ST_RUN;
                    mode_d   = MODE;
                    limit_d  = LIMIT;
                    cycles_d = CYCLES;
                    wcnt_d   = 4'd0;
                    cnt_d    = (MODE == MODE_DOWN) ? LIMIT : 3'd0;
                end
            end
            ST_RUN: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else if (HOLD) begin
                    state_d = ST_HOLD;
                end else if (at_term) begin
                    cnt_d  = start_val;
                    wrap_d = 1'b1;
                    if (cycles_q == 4'd0) begin
                        // free-running: wrap count saturates, run continues
                        wcnt_d = (wcnt_q == 4'hF) ? wcnt_q : wcnt_inc;
                    end else begin
                        wcnt_d = wcnt_inc;
                        if (wcnt_inc == cycles_q) begin
                            state_d = ST_FIN;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = down_run ? (cnt_q - 3'd1) : (cnt_q + 3'd1);
                end
            end
            ST_HOLD: begin
                if (STOP) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else if (!HOLD) begin
                    state_d = ST_RUN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);

`ifdef FF_SEQ_GRAY_EN
        q_d = (mode_d == MODE_GRAY) ? (cnt_d ^ (cnt_d >> 1)) : cnt_d;
`else
        q_d = cnt_d;
`endif
    end

    // State, configuration and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 3'd0;
            wcnt_q   <= 4'd0;
            mode_q   <= 2'd0;
            limit_q  <= 3'd0;
            cycles_q <= 4'd0;
            q_q      <= 3'd0;
            busy_q   <= 1'b0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            mode_q   <= mode_d;
            limit_q  <= limit_d;
            cycles_q <= cycles_d;
            q_q      <= q_d;
            busy_q   <= busy_d;
            wrap_q   <= wrap_d;
            done_q   <= done_d;
        end
    end

    assign Q2   = q_q[2];
    assign Q1   = q_q[1];
    assign Q0   = q_q[0];
    assign BUSY = busy_q;
    assign WRAP = wrap_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_ff_seq_ctrl.sv
// Directed testbench for ff_seq_ctrl with immediate-assertion checks.
module tb_ff_seq_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       START, STOP, HOLD;
    logic [1:0] MODE;
    logic [2:0] LIMIT;
    logic [3:0] CYCLES;
    logic       Q2, Q1, Q0, BUSY, WRAP, DONE;
    logic [2:0] q;

    int n_assert = 0;
    int n_fail   = 0;

    ff_seq_ctrl dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .HOLD(HOLD),
        .MODE(MODE), .LIMIT(LIMIT), .CYCLES(CYCLES),
        .Q2(Q2), .Q1(Q1), .Q0(Q0), .BUSY(BUSY), .WRAP(WRAP), .DONE(DONE)
    );

    always #5 CLK = ~CLK;
    assign q = {Q2, Q1, Q0};

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] eq, input logic eb,
                           input logic ew, input logic ed);
        chk({tag, "_q"}, {5'd0, q}, {5'd0, eq});
        chk({tag, "_busy"}, {7'd0, BUSY}, {7'd0, eb});
        chk({tag, "_wrap"}, {7'd0, WRAP}, {7'd0, ew});
        chk({tag, "_done"}, {7'd0, DONE}, {7'd0, ed});
    endtask

    function automatic logic [2:0] enc(input logic [2:0] b);
`ifdef FF_SEQ_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    initial begin
        logic [2:0] e;
        RST_N = 1'b0; START = 1'b1; STOP = 1'b0; HOLD = 1'b0;
        MODE = 2'b00; LIMIT = 3'd5; CYCLES = 4'd2;

        // reset overrides START
        tick(); tick();
        chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0);
        START = 1'b0; RST_N = 1'b1;
        tick();
        chk_all("idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // up, LIMIT=5, CYCLES=2; config changes mid-run are ignored
        START = 1'b1;
        tick();
        chk_all("up_entry", 3'd0, 1'b1, 1'b0, 1'b0);
        START = 1'b0; LIMIT = 3'd2; CYCLES = 4'd1; MODE = 2'b01;
        for (int i = 0; i < 12; i++) begin
            e = 3'((i + 1) % 6);
            tick();
            chk_all($sformatf("up_%0d", i), e, (i != 11), (e == 3'd0), (i == 11));
        end
        tick();
        chk_all("up_after_fin", 3'd0, 1'b0, 1'b0, 1'b0);

        // down, LIMIT=3, CYCLES=1
        MODE = 2'b01; LIMIT = 3'd3; CYCLES = 4'd1; START = 1'b1;
        tick();
        chk_all("dn_entry", 3'd3, 1'b1, 1'b0, 1'b0);
        START = 1'b0;
        tick(); chk_all("dn_2", 3'd2, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("dn_1", 3'd1, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("dn_0", 3'd0, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("dn_fin", 3'd3, 1'b0, 1'b1, 1'b1);
        tick(); chk_all("dn_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        // MODE=10, LIMIT=7, CYCLES=0 (Gray if enabled, else up); stop ends it
        MODE = 2'b10; LIMIT = 3'd7; CYCLES = 4'd0; START = 1'b1;
        tick();
        chk_all("g_entry", 3'd0, 1'b1, 1'b0, 1'b0);
        START = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk_all($sformatf("g_%0d", i), enc(3'(i % 8)), 1'b1, (i == 8), 1'b0);
        end
        STOP = 1'b1;
        tick();
        chk_all("g_stop", 3'd0, 1'b0, 1'b0, 1'b0);
        STOP = 1'b0;

        // hold at Q=4, START mid-run ignored
        MODE = 2'b00; LIMIT = 3'd7; CYCLES = 4'd0; START = 1'b1;
        tick();
        chk_all("h_entry", 3'd0, 1'b1, 1'b0, 1'b0);
        START = 1'b0;
        tick(); chk_all("h_1", 3'd1, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("h_2", 3'd2, 1'b1, 1'b0, 1'b0);
        START = 1'b1;
        tick(); chk_all("h_3_start", 3'd3, 1'b1, 1'b0, 1'b0);
        START = 1'b0;
        tick(); chk_all("h_4", 3'd4, 1'b1, 1'b0, 1'b0);
        HOLD = 1'b1;
        tick(); chk_all("h_hold1", 3'd4, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("h_hold2", 3'd4, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("h_hold3", 3'd4, 1'b1, 1'b0, 1'b0);
        HOLD = 1'b0;
        tick(); chk_all("h_resume", 3'd4, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("h_5", 3'd5, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("h_6", 3'd6, 1'b1, 1'b0, 1'b0);

        // reset mid-run at Q=6
        RST_N = 1'b0;
        tick(); chk_all("mid_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        RST_N = 1'b1;
        tick(); chk_all("post_reset", 3'd0, 1'b0, 1'b0, 1'b0);

        // START and STOP together in IDLE stays IDLE
        START = 1'b1; STOP = 1'b1;
        tick(); chk_all("start_stop", 3'd0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("start_stop2", 3'd0, 1'b0, 1'b0, 1'b0);
        STOP = 1'b0;

        // STOP beats HOLD while in HOLD; no DONE
        MODE = 2'b00; LIMIT = 3'd7; CYCLES = 4'd0;
        tick(); chk_all("s_entry", 3'd0, 1'b1, 1'b0, 1'b0);
        START = 1'b0;
        tick(); chk_all("s_1", 3'd1, 1'b1, 1'b0, 1'b0);
        HOLD = 1'b1;
        tick(); chk_all("s_hold", 3'd1, 1'b1, 1'b0, 1'b0);
        STOP = 1'b1;
        tick(); chk_all("s_stop", 3'd0, 1'b0, 1'b0, 1'b0);
        STOP = 1'b0; HOLD = 1'b0;

        // LIMIT=0: wrap every RUN cycle, CYCLES=3
        MODE = 2'b00; LIMIT = 3'd0; CYCLES = 4'd3; START = 1'b1;
        tick(); chk_all("l0_entry", 3'd0, 1'b1, 1'b0, 1'b0);
        START = 1'b0;
        tick(); chk_all("l0_w1", 3'd0, 1'b1, 1'b1, 1'b0);
        tick(); chk_all("l0_w2", 3'd0, 1'b1, 1'b1, 1'b0);
        tick(); chk_all("l0_fin", 3'd0, 1'b0, 1'b1, 1'b1);
        tick(); chk_all("l0_idle", 3'd0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
